// File: rtl/sar_pkg.sv
// Shared types and default parameters for the SAR ADC sequencer.
package sar_pkg;

   localparam int WIDTH_DEF        = 12;
   localparam int SAMPLE_TICKS_DEF = 4;
   localparam int SLOW_DIV_DEF     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } sar_state_e;

endpackage

// File: rtl/sar_sequencer_if.sv
// Control/status bundle between a host and the SAR sequencer.
interface sar_sequencer_if #(
   parameter int WIDTH = 12
);
   logic             adc_en_i;
   logic             start_conv_i;
   logic             start_cal_i;
   logic             auto_mode_i;
   logic             clk_sel_i;
   logic             vref_rdy_i;
   logic             cmp_i;
   logic             sample_o;
   logic             cal_mode_o;
   logic [WIDTH-1:0] dac_code_o;
   logic [WIDTH-1:0] adc_data_o;
   logic [WIDTH-1:0] cal_offset_o;
   logic             eoc_o;
   logic             busy_o;

   modport slave (
      input  adc_en_i, start_conv_i, start_cal_i, auto_mode_i, clk_sel_i, vref_rdy_i, cmp_i,
      output sample_o, cal_mode_o, dac_code_o, adc_data_o, cal_offset_o, eoc_o, busy_o
   );

   modport master (
      output adc_en_i, start_conv_i, start_cal_i, auto_mode_i, clk_sel_i, vref_rdy_i, cmp_i,
      input  sample_o, cal_mode_o, dac_code_o, adc_data_o, cal_offset_o, eoc_o, busy_o
   );
endinterface

// File: rtl/sar_tick_gen.sv
// Tick prescaler: down-counter reloaded on terminal count; divide ratio sampled at each reload.
module sar_tick_gen
   import sar_pkg::*;
#(
   parameter int SLOW_DIV = SLOW_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic clk_sel_i,
   output logic tick
);

   localparam logic [3:0] RELOAD_SLOW = 4'(SLOW_DIV - 1);

   logic [3:0] cnt_q, cnt_d, reload;

   always_comb begin
      reload = clk_sel_i ? RELOAD_SLOW : 4'd0;
      tick   = 1'b0;
      cnt_d  = cnt_q;
      if (clear) begin
         cnt_d = reload;
      end else if (cnt_q == 4'd0) begin
         tick  = 1'b1;
         cnt_d = reload;
      end else begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= 4'd0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sar_sequencer.sv
// SAR ADC conversion/calibration sequencer. Optional offset subtraction on
// conversion results is enabled by defining SAR_OFFSET_CORR_EN.
//
// state   | meaning
// IDLE    | waiting for a start edge, DAC parked at 0
// SAMPLE  | track switch closed for SAMPLE_TICKS ticks (input grounded if cal)
// CONVERT | binary search, one bit per tick, MSB first
// DONE    | one clk: latch result into adc_data or cal_offset
module sar_sequencer
   import sar_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter int SAMPLE_TICKS = SAMPLE_TICKS_DEF,
   parameter int SLOW_DIV     = SLOW_DIV_DEF
) (
   input logic             clk,
   input logic             reset,
   sar_sequencer_if.slave  bus
);

   localparam int               IDX_W     = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
   localparam logic [3:0]       SAMP_LOAD = 4'(SAMPLE_TICKS - 1);
   localparam logic [WIDTH-1:0] DAC_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_e       state_q, state_d;
   logic             cal_q, cal_d;
   logic             conv_r_q, conv_r_d;
   logic             cal_r_q, cal_r_d;
   logic [3:0]       samp_cnt_q, samp_cnt_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [WIDTH-1:0] dac_q, dac_d;
   logic [WIDTH-1:0] adc_q, adc_d;
   logic [WIDTH-1:0] off_q, off_d;
   logic             eoc_q, eoc_d;

   logic             tick;
   logic             conv_rise, cal_rise;
   logic [WIDTH-1:0] result;

   sar_tick_gen #(.SLOW_DIV(SLOW_DIV)) u_tick_gen (
      .clk       (clk),
      .reset     (reset),
      .clear     ((state_q == ST_IDLE) || (state_q == ST_DONE)),
      .clk_sel_i (bus.clk_sel_i),
      .tick      (tick)
   );

   assign conv_rise = bus.start_conv_i & ~conv_r_q;
   assign cal_rise  = bus.start_cal_i  & ~cal_r_q;

`ifdef SAR_OFFSET_CORR_EN
   assign result = (dac_q >= off_q) ? (dac_q - off_q) : '0;
`else
   assign result = dac_q;
`endif

   always_comb begin
      state_d    = state_q;
      cal_d      = cal_q;
      conv_r_d   = bus.start_conv_i;
      cal_r_d    = bus.start_cal_i;
      samp_cnt_d = samp_cnt_q;
      bit_idx_d  = bit_idx_q;
      dac_d      = dac_q;
      adc_d      = adc_q;
      off_d      = off_q;
      eoc_d      = eoc_q;

      case (state_q)
         ST_IDLE: begin
            dac_d = '0;
            // Calibration wins a same-cycle tie; edges outside enable/vref are simply dropped
            if (bus.adc_en_i && bus.vref_rdy_i && (cal_rise || conv_rise)) begin
               state_d    = ST_SAMPLE;
               cal_d      = cal_rise;
               samp_cnt_d = SAMP_LOAD;
            end
         end
         ST_SAMPLE: begin
            if (!cal_q) eoc_d = 1'b0;
            if (tick) begin
               if (samp_cnt_q == 4'd0) begin
                  state_d   = ST_CONVERT;
                  bit_idx_d = IDX_MSB;
                  dac_d     = DAC_MSB;
               end else begin
                  samp_cnt_d = samp_cnt_q - 4'd1;
               end
            end
         end
         ST_CONVERT: begin
            if (tick) begin
               dac_d[bit_idx_q] = bus.cmp_i;
               if (bit_idx_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  bit_idx_d                      = bit_idx_q - IDX_W'(1);
                  dac_d[bit_idx_q - IDX_W'(1)]   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (cal_q) begin
               off_d = dac_q;
            end else begin
               adc_d = result;
               eoc_d = 1'b1;
            end
            dac_d = '0;
            if (bus.auto_mode_i && bus.adc_en_i && !cal_q) begin
               state_d    = ST_SAMPLE;
               samp_cnt_d = SAMP_LOAD;
            end else begin
               state_d = ST_IDLE;
               cal_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Enable drop aborts from anywhere, leaving published results untouched
      if (state_q != ST_IDLE && !bus.adc_en_i) begin
         state_d = ST_IDLE;
         cal_d   = 1'b0;
         dac_d   = '0;
         adc_d   = adc_q;
         off_d   = off_q;
         eoc_d   = eoc_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cal_q      <= 1'b0;
         conv_r_q   <= 1'b0;
         cal_r_q    <= 1'b0;
         samp_cnt_q <= 4'd0;
         bit_idx_q  <= '0;
         dac_q      <= '0;
         adc_q      <= '0;
         off_q      <= '0;
         eoc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cal_q      <= cal_d;
         conv_r_q   <= conv_r_d;
         cal_r_q    <= cal_r_d;
         samp_cnt_q <= samp_cnt_d;
         bit_idx_q  <= bit_idx_d;
         dac_q      <= dac_d;
         adc_q      <= adc_d;
         off_q      <= off_d;
         eoc_q      <= eoc_d;
      end
   end

   assign bus.sample_o     = (state_q == ST_SAMPLE);
   assign bus.busy_o       = (state_q == ST_SAMPLE) || (state_q == ST_CONVERT);
   assign bus.cal_mode_o   = bus.busy_o && cal_q;
   assign bus.dac_code_o   = dac_q;
   assign bus.adc_data_o   = adc_q;
   assign bus.cal_offset_o = off_q;
   assign bus.eoc_o        = eoc_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer with a behavioural comparator driven from an analog level.
module tb_sar_sequencer;

`ifdef SAR_OFFSET_CORR_EN
   localparam bit CORR = 1'b1;
`else
   localparam bit CORR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] vin;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n;
   logic [11:0] prev_adc;

   sar_sequencer_if #(.WIDTH(12)) sif ();

   sar_sequencer #(.WIDTH(12), .SAMPLE_TICKS(4), .SLOW_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   assign sif.cmp_i = (vin >= sif.dac_code_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_eoc(input int start, input int bound, output int cnt);
      cnt = start;
      do begin
         step();
         cnt++;
      end while (sif.eoc_o !== 1'b1 && cnt < bound);
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (sif.busy_o === 1'b1 && k < bound) begin
         step();
         k++;
      end
      chk("idle_reached", 32'(sif.busy_o), 0);
      step();
   endtask

   function automatic logic [11:0] exp_adc(input logic [11:0] raw, input logic [11:0] off);
      logic [11:0] corr;
      corr = (raw >= off) ? raw - off : 12'h000;
      return CORR ? corr : raw;
   endfunction

   initial begin
      reset            = 1'b1;
      vin              = 12'h000;
      sif.adc_en_i     = 1'b0;
      sif.start_conv_i = 1'b0;
      sif.start_cal_i  = 1'b0;
      sif.auto_mode_i  = 1'b0;
      sif.clk_sel_i    = 1'b0;
      sif.vref_rdy_i   = 1'b0;
      step();
      step();
      chk("rst_busy",    32'(sif.busy_o), 0);
      chk("rst_sample",  32'(sif.sample_o), 0);
      chk("rst_calmode", 32'(sif.cal_mode_o), 0);
      chk("rst_dac",     32'(sif.dac_code_o), 0);
      chk("rst_adc",     32'(sif.adc_data_o), 0);
      chk("rst_off",     32'(sif.cal_offset_o), 0);
      chk("rst_eoc",     32'(sif.eoc_o), 0);

      reset          = 1'b0;
      sif.adc_en_i   = 1'b1;
      sif.vref_rdy_i = 1'b1;
      step();

      // Plain conversion of 0xA5C at one tick per clk
      vin              = 12'hA5C;
      sif.start_conv_i = 1'b1;
      step();
      chk("c1_sample", 32'(sif.sample_o), 1);
      chk("c1_busy",   32'(sif.busy_o), 1);
      chk("c1_dac0",   32'(sif.dac_code_o), 0);
      repeat (3) step();
      chk("c1_sample_last", 32'(sif.sample_o), 1);
      step();
      chk("c1_dac_msb",   32'(sif.dac_code_o), 32'h800);
      chk("c1_sample_off", 32'(sif.sample_o), 0);
      step();
      chk("c1_dac_2nd", 32'(sif.dac_code_o), 32'hC00);
      wait_eoc(5, 60, n);
      chk("c1_eoc_clks", n, 17);
      chk("c1_adc",      32'(sif.adc_data_o), 32'hA5C);
      chk("c1_busy_end", 32'(sif.busy_o), 0);
      chk("c1_dac_idle", 32'(sif.dac_code_o), 0);

      // Offset calibration of 0x007
      sif.start_conv_i = 1'b0;
      vin              = 12'h007;
      sif.start_cal_i  = 1'b1;
      step();
      chk("cal1_mode",   32'(sif.cal_mode_o), 1);
      chk("cal1_sample", 32'(sif.sample_o), 1);
      wait_idle(100);
      chk("cal1_off",     32'(sif.cal_offset_o), 32'h007);
      chk("cal1_eoc_kept", 32'(sif.eoc_o), 1);
      chk("cal1_adc_kept", 32'(sif.adc_data_o), 32'hA5C);
      sif.start_cal_i = 1'b0;

      // Conversion of 0x100 after calibration
      vin              = 12'h100;
      sif.start_conv_i = 1'b1;
      step();
      step();
      chk("c2_eoc_cleared", 32'(sif.eoc_o), 0);
      wait_eoc(1, 60, n);
      chk("c2_eoc_clks", n, 17);
      prev_adc = exp_adc(12'h100, 12'h007);
      chk("c2_adc", 32'(sif.adc_data_o), 32'(prev_adc));

      // Abort when CONVERT reaches bit index 5
      vin              = 12'h3C3;
      sif.start_conv_i = 1'b0;
      step();
      sif.start_conv_i = 1'b1;
      step();
      repeat (10) step();
      chk("ab_dac_idx5", 32'(sif.dac_code_o), 32'h3E0);
      sif.adc_en_i = 1'b0;
      step();
      chk("ab_busy",   32'(sif.busy_o), 0);
      chk("ab_sample", 32'(sif.sample_o), 0);
      chk("ab_dac",    32'(sif.dac_code_o), 0);
      chk("ab_adc",    32'(sif.adc_data_o), 32'(prev_adc));
      chk("ab_eoc",    32'(sif.eoc_o), 0);
      sif.adc_en_i = 1'b1;

      // Simultaneous rises: calibration wins; rises while busy are dropped
      sif.start_conv_i = 1'b0;
      step();
      vin              = 12'h00A;
      sif.start_conv_i = 1'b1;
      sif.start_cal_i  = 1'b1;
      step();
      chk("tie_calmode", 32'(sif.cal_mode_o), 1);
      sif.start_conv_i = 1'b0;
      step();
      sif.start_conv_i = 1'b1;
      step();
      wait_idle(100);
      chk("tie_off", 32'(sif.cal_offset_o), 32'h00A);
      chk("tie_adc", 32'(sif.adc_data_o), 32'(prev_adc));
      repeat (3) step();
      chk("busy_rise_dropped", 32'(sif.busy_o), 0);

      // No start while the reference is not ready
      sif.start_conv_i = 1'b0;
      sif.start_cal_i  = 1'b0;
      step();
      sif.vref_rdy_i   = 1'b0;
      sif.start_conv_i = 1'b1;
      step();
      chk("vref_nostart_a", 32'(sif.busy_o), 0);
      step();
      chk("vref_nostart_b", 32'(sif.busy_o), 0);
      sif.vref_rdy_i = 1'b1;
      step();
      chk("vref_no_late_start", 32'(sif.busy_o), 0);

      // Auto mode on the slow tick: 4*(4+12)+1 clks per conversion
      sif.start_conv_i = 1'b0;
      sif.clk_sel_i    = 1'b1;
      sif.auto_mode_i  = 1'b1;
      vin              = 12'h555;
      step();
      sif.start_conv_i = 1'b1;
      step();
      wait_eoc(0, 200, n);
      chk("auto1_clks", n, 65);
      chk("auto1_adc",  32'(sif.adc_data_o), 32'(exp_adc(12'h555, 12'h00A)));
      vin = 12'h2AA;
      step();
      chk("auto2_eoc_low", 32'(sif.eoc_o), 0);
      chk("auto2_busy",    32'(sif.busy_o), 1);
      sif.auto_mode_i = 1'b0;
      wait_eoc(1, 200, n);
      chk("auto2_clks", n, 65);
      chk("auto2_adc",  32'(sif.adc_data_o), 32'(exp_adc(12'h2AA, 12'h00A)));
      repeat (3) step();
      chk("auto_stop_busy",   32'(sif.busy_o), 0);
      chk("auto_stop_sample", 32'(sif.sample_o), 0);
      sif.start_conv_i = 1'b0;
      sif.clk_sel_i    = 1'b0;
      step();

      // Offset larger than the input
      vin             = 12'h010;
      sif.start_cal_i = 1'b1;
      step();
      wait_idle(100);
      chk("cal2_off", 32'(sif.cal_offset_o), 32'h010);
      sif.start_cal_i  = 1'b0;
      vin              = 12'h008;
      sif.start_conv_i = 1'b1;
      step();
      wait_eoc(1, 60, n);
      chk("sat_adc", 32'(sif.adc_data_o), 32'(exp_adc(12'h008, 12'h010)));
      sif.start_conv_i = 1'b0;
      step();

      // Reset in the middle of a conversion
      vin              = 12'h123;
      sif.start_conv_i = 1'b1;
      step();
      repeat (6) step();
      chk("mid_busy", 32'(sif.busy_o), 1);
      reset = 1'b1;
      #1;
      chk("mrst_busy", 32'(sif.busy_o), 0);
      chk("mrst_dac",  32'(sif.dac_code_o), 0);
      chk("mrst_adc",  32'(sif.adc_data_o), 0);
      chk("mrst_off",  32'(sif.cal_offset_o), 0);
      chk("mrst_eoc",  32'(sif.eoc_o), 0);
      sif.start_conv_i = 1'b0;
      step();
      reset = 1'b0;
      repeat (20) step();
      chk("post_rst_adc",  32'(sif.adc_data_o), 0);
      chk("post_rst_eoc",  32'(sif.eoc_o), 0);
      chk("post_rst_busy", 32'(sif.busy_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
